// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads, registers the returned word for
// decode, and drops the stale response of a request that was in flight when a branch hit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        instruction_valid,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;

    logic        xfer;
    logic [31:0] redirect_pc;

    // A held valid word under stall suppresses the request; reset suppresses it immediately.
    assign imem_req    = !reset && (state_q == FETCH || state_q == DISCARD) && !(valid_q && stall);
    assign imem_addr   = (state_q == DISCARD) ? hold_addr_q : pc_q;
    assign xfer        = imem_req && imem_ready;
    assign redirect_pc = {branch_target[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_addr_d  = hold_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q && stall;
        misaligned_d = branch_taken && (branch_target[1:0] != 2'b00);
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (branch_taken) pc_d = redirect_pc;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    // Request still in flight: its response must be thrown away later.
                    if (imem_req && !imem_ready) begin
                        state_d     = DISCARD;
                        hold_addr_d = pc_q;
                    end
                end else if (xfer) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (xfer) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            instr_pc_q   <= 32'h00000000;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_ff @(posedge clock) begin
        hold_addr_q <= hold_addr_d;
    end

    assign instruction       = instr_q;
    assign instruction_pc    = instr_pc_q;
    assign instruction_valid = valid_q;
    assign misaligned        = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset, imem_ready, branch_taken, stall;
    logic [31:0] imem_rdata, branch_target;
    logic        imem_req, instruction_valid, misaligned;
    logic [31:0] imem_addr, instruction, instruction_pc;
    logic        d2_req, d2_valid, d2_mis;
    logic [31:0] d2_addr, d2_instr, d2_ipc;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: fetch pointer, whether a stale response is still owed, and the visible word.
    logic        m_started, m_drop, m_valid, m_mis;
    logic [31:0] m_pc, m_stale, m_instr, m_ipc;
    logic        exp_req;
    logic [31:0] exp_addr;

    fetch_unit dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall), .instruction(instruction),
        .instruction_pc(instruction_pc), .instruction_valid(instruction_valid),
        .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .clock(clock), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall), .instruction(d2_instr),
        .instruction_pc(d2_ipc), .instruction_valid(d2_valid), .misaligned(d2_mis)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic r, input logic rdy, input logic [31:0] rd,
                         input logic bt, input logic [31:0] tgt, input logic st);
        reset = r; imem_ready = rdy; imem_rdata = rd;
        branch_taken = bt; branch_target = tgt; stall = st;
        exp_req  = !r && m_started && !(m_valid && st);
        exp_addr = m_drop ? m_stale : m_pc;
    endtask

    task automatic tick();
        logic xfer;
        @(posedge clock);
        if (reset) begin
            m_started = 0; m_pc = 32'h0; m_drop = 0; m_instr = 32'h00000013;
            m_ipc = 32'h0; m_valid = 0; m_mis = 0;
        end else begin
            xfer  = exp_req && imem_ready;
            m_mis = branch_taken && (branch_target[1:0] != 2'b00);
            if (!m_started) begin
                m_started = 1;
                if (branch_taken) m_pc = {branch_target[31:2], 2'b00};
            end else if (branch_taken) begin
                if (!m_drop && exp_req && !imem_ready) begin
                    m_drop = 1; m_stale = m_pc;
                end
                m_pc = {branch_target[31:2], 2'b00};
                m_valid = 0;
            end else if (xfer) begin
                if (m_drop) m_drop = 0;
                else begin
                    m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
                end
            end else begin
                m_valid = m_valid && stall;
            end
        end
        @(negedge clock);
    endtask

    task automatic start();
        drive(1, 0, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic fetch_words(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, $urandom, 0, 0, 0); tick();
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0); tick(); tick();
        n_tests++; if (instruction !== 32'h00000013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instruction); end
        n_tests++; if (instruction_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ipc: got %h want 0", instruction_pc); end
        n_tests++; if (instruction_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instruction_valid); end
        n_tests++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        drive(0, 1, 0, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b want 0", imem_req); end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 32'(4 * i), 0, 0, 0); #1;
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr: got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'(4 * i)); end
            tick();
            n_tests++; if (instruction_pc !== 32'(4 * i) || instruction !== 32'(4 * i) || instruction_valid !== 1'b1) begin n_fail++; $display("FAIL seq_out: got pc=%h instr=%h v=%b want %h", instruction_pc, instruction, instruction_valid, 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        start();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, (i == 2) ? 32'h00A12023 : $urandom, 0, 0, 0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, $urandom, 0, 0, 1); #1;
            n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_req: got req=%b addr=%h want 0 0000000c", imem_req, imem_addr); end
            tick();
            n_tests++; if (instruction !== 32'h00A12023 || instruction_pc !== 32'h8 || instruction_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %h pc=%h v=%b want 00a12023 8 1", instruction, instruction_pc, instruction_valid); end
        end
        drive(0, 1, 32'h1234, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want 1 0000000c", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_branch_wait();
        start();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, (i == 3) ? 32'h1111000C : $urandom, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL bw_wait1: got req=%b addr=%h want 1 00000010", imem_req, imem_addr); end
        tick();
        drive(0, 0, 0, 1, 32'h40, 0); #1;
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL bw_wait2: got addr=%h want 00000010", imem_addr); end
        tick();
        n_tests++; if (instruction_valid !== 1'b0) begin n_fail++; $display("FAIL bw_valid: got %b want 0", instruction_valid); end
        drive(0, 1, 32'hDEADBEEF, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL bw_held: got req=%b addr=%h want 1 00000010", imem_req, imem_addr); end
        tick();
        n_tests++; if (instruction_valid !== 1'b0 || instruction !== 32'h1111000C) begin n_fail++; $display("FAIL bw_drop: got %h v=%b want 1111000c 0", instruction, instruction_valid); end
        drive(0, 1, 32'h0000600D, 0, 0, 0); #1;
        n_tests++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL bw_target: got addr=%h want 00000040", imem_addr); end
        tick();
        n_tests++; if (instruction !== 32'h600D || instruction_pc !== 32'h40 || instruction_valid !== 1'b1) begin n_fail++; $display("FAIL bw_new: got %h pc=%h v=%b want 0000600d 40 1", instruction, instruction_pc, instruction_valid); end
    endtask

    task automatic test_misaligned();
        start();
        fetch_words(2);
        drive(0, 1, 32'hBAD0BAD0, 1, 32'h102, 0); tick();
        n_tests++; if (instruction_valid !== 1'b0 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got v=%b mis=%b want 0 1", instruction_valid, misaligned); end
        drive(0, 1, 32'h77, 0, 0, 0); #1;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h want 00000100", imem_addr); end
        tick();
        n_tests++; if (misaligned !== 1'b0 || instruction_pc !== 32'h100 || instruction !== 32'h77) begin n_fail++; $display("FAIL mis_after: got mis=%b pc=%h instr=%h want 0 100 77", misaligned, instruction_pc, instruction); end
    endtask

    task automatic test_wrap();
        start();
        drive(0, 1, 32'hCAFE, 0, 0, 0); #1;
        n_tests++; if (d2_req !== 1'b1 || d2_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h want 1 fffffffc", d2_req, d2_addr); end
        tick();
        n_tests++; if (d2_ipc !== 32'hFFFFFFFC || d2_valid !== 1'b1 || d2_instr !== 32'hCAFE) begin n_fail++; $display("FAIL wrap_out: got pc=%h v=%b instr=%h want fffffffc 1 cafe", d2_ipc, d2_valid, d2_instr); end
        drive(0, 1, 32'h1, 0, 0, 0); #1;
        n_tests++; if (d2_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want 00000000", d2_addr); end
        tick();
    endtask

    task automatic test_reset_mid();
        start();
        fetch_words(1);
        drive(0, 0, 0, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", imem_req); end
        tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        n_tests++; if (instruction_valid !== 1'b0 || instruction !== 32'h00000013 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_state: got v=%b instr=%h req=%b want 0 00000013 0", instruction_valid, instruction, imem_req); end
        drive(0, 1, 0, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got %b want 0", imem_req); end
        tick();
        drive(0, 1, 32'h55, 0, 0, 0); #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_refetch: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        tick();
        n_tests++; if (instruction !== 32'h55 || instruction_valid !== 1'b1) begin n_fail++; $display("FAIL rm_keep: got %h v=%b want 00000055 1", instruction, instruction_valid); end
    endtask

    task automatic test_random();
        start();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) == 0);
            #1;
            n_tests++; if (imem_req !== exp_req || imem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h want %b %h", i, imem_req, imem_addr, exp_req, exp_addr); end
            tick();
            n_tests++; if (instruction !== m_instr || instruction_pc !== m_ipc || instruction_valid !== m_valid || misaligned !== m_mis) begin n_fail++; $display("FAIL rnd_out[%0d]: got %h %h %b %b want %h %h %b %b", i, instruction, instruction_pc, instruction_valid, misaligned, m_instr, m_ipc, m_valid, m_mis); end
        end
    endtask

    initial begin
        reset = 1; imem_ready = 0; imem_rdata = 0; branch_taken = 0; branch_target = 0; stall = 0;
        m_started = 0; m_drop = 0; m_valid = 0; m_mis = 0;
        m_pc = 0; m_stale = 0; m_instr = 32'h00000013; m_ipc = 0;
        @(negedge clock);
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
